// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, primary
// opcodes, and the ALU / operand-mux / PC-source select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM (Moore outputs, BEQ pc_en from zero).
// Optional MULTICYCLE_CTRL_MEM_WAIT_EN: memory states stall until mem_ready.
//
// state  | meaning
// INIT   | post-reset idle, all controls low
// FETCH  | read instruction, PC <= PC+4
// DECODE | load A/B, precompute branch target, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | data memory read
// MEMWB  | write loaded word to rt
// MEMWR  | data memory write
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare, PC <= target if zero
// JUMP   | PC <= jump target
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to rt
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            ab_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic [3:0]      state,
    output logic            illegal
);

    state_e state_q, state_d;
    logic   mem_wait;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_wait = ~mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_wait = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        ab_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        illegal    = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // A stalled fetch must not latch IR or bump the PC
                ir_write  = ~mem_wait;
                pc_en     = ~mem_wait;
                if (!mem_wait) state_d = S_DECODE;
            end
            S_DECODE: begin
                ab_write  = 1'b1;
                alu_src_b = SRCB_IMM_SH;
                if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) state_d = S_MEMADR;
                else if (opcode == OP_W'(OP_RTYPE)) state_d = S_EXEC;
                else if (opcode == OP_W'(OP_BEQ))   state_d = S_BRANCH;
                else if (opcode == OP_W'(OP_J))     state_d = S_JUMP;
                else if (opcode == OP_W'(OP_ADDI))  state_d = S_ADDIEX;
                else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (!mem_wait) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (!mem_wait) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state paths and
// control words from a table model; build with MULTICYCLE_CTRL_MEM_WAIT_EN to check stalls.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_en, iord, mem_read, mem_write, ir_write, ab_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    multicycle_ctrl #(.OP_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .ab_write(ab_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [16:0] ctrl_now = {pc_en, iord, mem_read, mem_write, ir_write, ab_write,
                            reg_write, reg_dst, mem_to_reg, alu_src_a,
                            alu_src_b, alu_op, pc_src, illegal};

    int vectors = 0;
    int errors  = 0;
    int path[$];
    int wr_cycles;

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Sequence of states one instruction walks through, FETCH first.
    function automatic void build_path(logic [5:0] op);
        path = {1, 2};
        case (op)
            6'b100011: path = {path, 3, 4, 5};
            6'b101011: path = {path, 3, 6};
            6'b000000: path = {path, 7, 8};
            6'b000100: path = {path, 9};
            6'b000010: path = {path, 10};
            6'b001000: path = {path, 11, 12};
            default: ;
        endcase
    endfunction

    // Control word required in state s, packed in the same order as ctrl_now.
    function automatic logic [16:0] exp_ctrl(int s, logic z, bit stall, logic [5:0] op);
        logic pce, io, mr, mw, irw, abw, rw, rd, m2r, sa, ill;
        logic [1:0] sb, ao, ps;
        {pce, io, mr, mw, irw, abw, rw, rd, m2r, sa, ill} = '0;
        sb = 2'd0; ao = 2'd0; ps = 2'd0;
        case (s)
            1:  begin mr = 1; sb = 2'd1; irw = !stall; pce = !stall; end
            2:  begin abw = 1; sb = 2'd3; ill = !is_legal(op); end
            3:  begin sa = 1; sb = 2'd2; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin sa = 1; ao = 2'd2; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; ao = 2'd1; ps = 2'd1; pce = z; end
            10: begin ps = 2'd2; pce = 1; end
            11: begin sa = 1; sb = 2'd2; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pce, io, mr, mw, irw, abw, rw, rd, m2r, sa, sb, ao, ps, ill};
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic z, input int waits, input string tag);
        logic [16:0] exp_v;
        build_path(op);
        wr_cycles = 0;
        foreach (path[i]) begin
            int  s = path[i];
            bit  memst = (s == 1 || s == 4 || s == 6);
            int  w = (WAIT_EN && memst) ? waits : 0;
            for (int k = 0; k <= w; k++) begin
                opcode = op;
                zero   = z;
                if (WAIT_EN) mem_ready = (k == w);
                else         mem_ready = (waits == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                exp_v = exp_ctrl(s, z, WAIT_EN && memst && (k < w), op);
                vectors++;
                if (state !== 4'(s) || ctrl_now !== exp_v) begin
                    $display("FAIL %s step %0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                             tag, i, state, ctrl_now, s, exp_v);
                    errors++;
                end
                if (mem_write) wr_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            opcode = 6'($urandom);
            zero   = 1'($urandom);
            #1;
            vectors++;
            if (state !== 4'd0 || ctrl_now !== 17'd0) begin
                $display("FAIL reset_hold: state=%0d ctrl=%h, expected state=0 ctrl=0", state, ctrl_now);
                errors++;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0) begin
            $display("FAIL reset_release: state=%0d, expected 0", state);
            errors++;
        end
        @(negedge clk);
        vectors++;
        if (state !== 4'd1) begin
            $display("FAIL first_fetch: state=%0d, expected 1", state);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b000000;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (state !== 4'd7) begin
            $display("FAIL reach_exec: state=%0d, expected 7", state);
            errors++;
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || ctrl_now !== 17'd0) begin
            $display("FAIL async_reset: state=%0d ctrl=%h, expected state=0 ctrl=0", state, ctrl_now);
            errors++;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (state !== 4'd0 || reg_write !== 1'b0) begin
                $display("FAIL reset_no_write: state=%0d reg_write=%b, expected state=0 reg_write=0",
                         state, reg_write);
                errors++;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || reg_write !== 1'b0) begin
            $display("FAIL mid_release: state=%0d reg_write=%b, expected state=0 reg_write=0",
                     state, reg_write);
            errors++;
        end
        @(negedge clk);
        vectors++;
        if (state !== 4'd1) begin
            $display("FAIL mid_refetch: state=%0d, expected 1", state);
            errors++;
        end
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 1'($urandom), 0, "lw");
        run_instr(6'b001000, 1'($urandom), 0, "addi");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 1'b1, 0, "beq_taken");
        run_instr(6'b000100, 1'b0, 0, "beq_not_taken");
    endtask

    task automatic test_illegal();
        logic [5:0] op;
        run_instr(6'b111111, 1'b0, 0, "illegal_3f");
        for (int n = 0; n < 4; n++) begin
            do op = 6'($urandom); while (is_legal(op));
            run_instr(op, 1'($urandom), 0, "illegal_rand");
        end
    endtask

    task automatic test_back_to_back();
        run_instr(6'b000000, 1'b0, 0, "rtype");
        run_instr(6'b000010, 1'b0, 0, "jump");
        run_instr(6'b101011, 1'b0, 0, "sw");
    endtask

    task automatic test_mem_wait();
        run_instr(6'b101011, 1'b0, 3, "sw_wait");
        vectors++;
        if (wr_cycles !== (WAIT_EN ? 4 : 1)) begin
            $display("FAIL sw_wait_len: mem_write cycles=%0d, expected %0d", wr_cycles, WAIT_EN ? 4 : 1);
            errors++;
        end
        run_instr(6'b100011, 1'b0, 2, "lw_wait");
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, 1'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_mem_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
